// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding, default
// operand width and the iteration-counter width helper.
package Pkg_Global;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index iterations 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_seq_bit_counter.sv
// bit_counter: up-counter with synchronous clear/enable, async active-low
// reset, and a flag that is high while the count equals TC.
module bit_counter #(
  parameter int           W  = 2,
  parameter logic [W-1:0] TC = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Count enabled cycles; clear has priority over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == TC);

endmodule

// File: rtl/mult_seq.sv
// mult_seq: shift-add multiplier, one iteration per cycle, N iterations.
// Start-to-done latency N+1 cycles; product held until the next completion.
// Build option MULT_SEQ_SIGNED_EN: two's-complement operands (magnitude
// loop plus final conditional negation); undefined gives an unsigned build.
module mult_seq
  import Pkg_Global::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           done,
  output logic           busy
);

  localparam int CW = cnt_w(N);
  localparam int PW = 2 * N;

  state_t        r_state;
  logic [PW-1:0] r_mcand;
  logic [N-1:0]  r_mplr;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_product;
  logic          r_done;
  logic          r_busy;

  logic [N-1:0]  w_opa;
  logic [N-1:0]  w_opb;
  logic [PW-1:0] w_acc_next;
  logic [PW-1:0] w_result;
  logic [CW-1:0] w_cnt;
  logic          w_tc;

`ifdef MULT_SEQ_SIGNED_EN
  logic r_neg;
  logic w_neg;

  // Magnitudes fit unsigned in N bits, including the most negative value.
  assign w_opa = multiplicand[N-1] ? (~multiplicand + {{(N-1){1'b0}}, 1'b1}) : multiplicand;
  assign w_opb = multiplier[N-1]   ? (~multiplier   + {{(N-1){1'b0}}, 1'b1}) : multiplier;
  assign w_neg = multiplicand[N-1] ^ multiplier[N-1];
  assign w_result = r_neg ? (~w_acc_next + {{(PW-1){1'b0}}, 1'b1}) : w_acc_next;

  // Sign of the result, captured alongside the operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_neg <= 1'b0;
    else if (r_state == IDLE && start) r_neg <= w_neg;
  end
`else
  assign w_opa    = multiplicand;
  assign w_opb    = multiplier;
  assign w_result = w_acc_next;
`endif

  // Accumulator value after the current iteration's conditional add.
  assign w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

  // Iteration counter: held clear while idle, advances once per RUN cycle.
  bit_counter #(
    .W  (CW),
    .TC (CW'(N - 1))
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == IDLE),
    .i_en    (r_state == RUN),
    .o_count (w_cnt),
    .o_tc    (w_tc)
  );

  // Iteration index is kept for debug visibility only.
  logic w_unused_cnt;
  assign w_unused_cnt = ^w_cnt;

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= {{N{1'b0}}, w_opa};
            r_mplr  <= w_opb;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          if (w_tc) begin
            r_product <= w_result;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign product = r_product;
  assign done    = r_done;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq (N=4), scoreboard driven.
module tb_mult_seq;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [7:0] product;
  logic       done;
  logic       busy;

  mult_seq #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .product      (product),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int d_prev = -100;
  int d_gap  = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [7:0] p;
    int         e;
  } exp_t;
  exp_t sb[$];
  exp_t t;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
`ifdef MULT_SEQ_SIGNED_EN
    logic signed [7:0] sx;
    logic signed [7:0] sy;
    sx = {{4{x[3]}}, x};
    sy = {{4{y[3]}}, y};
    return 8'(sx * sy);
`else
    return 8'({4'b0, x} * {4'b0, y});
`endif
  endfunction

  // Monitor: sample just after each rising edge, pop on done.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (rst && done) begin
      chk("done_width", {15'b0, prev_done}, 16'd0);
      if (sb.size() == 0) begin
        chk("spurious_done", 16'd1, 16'd0);
      end else begin
        t = sb.pop_front();
        chk("product", {8'b0, product}, {8'b0, t.p});
        chk("latency", 16'(cyc - t.e), 16'(N));
      end
      d_gap  = cyc - d_prev;
      d_prev = cyc;
    end
    prev_done = rst & done;
  end

  task automatic issue(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    sb.push_back('{model(x, y), cyc + 1});
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 16'(sb.size()) | {15'b0, busy}, 16'd0);
  endtask

  task automatic one(input logic [3:0] x, input logic [3:0] y);
    issue(x, y);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  initial begin
    int bc;
    logic [3:0] ta [3];
    logic [3:0] tb [3];
    logic [7:0] tp [3];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_product", {8'b0, product}, 16'd0);
    chk("rst_done", {15'b0, done}, 16'd0);
    chk("rst_busy", {15'b0, busy}, 16'd0);
    rst = 1'b1;
    @(negedge clk);

    // 3x5 with busy length
    issue(4'd3, 4'd5);
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_len", 16'(bc), 16'd5);
    drain();
    chk("p_3x5", {8'b0, product}, 16'h000F);

    // 15x15 then 0x9, previous product held during the second run
    one(4'd15, 4'd15);
    issue(4'd0, 4'd9);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold", {8'b0, product}, {8'b0, model(4'd15, 4'd15)});
    drain();
    chk("p_0x9", {8'b0, product}, 16'h0000);

    // 6x7 with operand churn during RUN, start held into a back-to-back op
    issue(4'd6, 4'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 4'($urandom);
      b = 4'($urandom);
    end
    @(negedge clk);
    a = 4'd9;
    b = 4'd11;
    sb.push_back('{model(4'd9, 4'd11), cyc + 1});
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("b2b_gap", 16'(d_gap), 16'd6);

    // Reset two cycles into RUN aborts the operation
    issue(4'd2, 4'd3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_product", {8'b0, product}, 16'd0);
    chk("abort_done", {15'b0, done}, 16'd0);
    chk("abort_busy", {15'b0, busy}, 16'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    one(4'd2, 4'd2);
    chk("p_2x2", {8'b0, product}, 16'h0004);

    // Build-specific known products
`ifdef MULT_SEQ_SIGNED_EN
    ta = '{4'hD, 4'h8, 4'h7};
    tb = '{4'h5, 4'h8, 4'hF};
    tp = '{8'hF1, 8'h40, 8'hF9};
    for (int i = 0; i < 3; i++) begin
      one(ta[i], tb[i]);
      chk("p_signed", {8'b0, product}, {8'b0, tp[i]});
    end
`else
    ta = '{4'hD, 4'hF, 4'h8};
    tb = '{4'h5, 4'h1, 4'h8};
    tp = '{8'h41, 8'h0F, 8'h40};
    for (int i = 0; i < 3; i++) begin
      one(ta[i], tb[i]);
      chk("p_unsigned", {8'b0, product}, {8'b0, tp[i]});
    end
`endif

    // Random operands against the model
    for (int i = 0; i < 8; i++) begin
      one(4'($urandom), 4'($urandom));
    end

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
# mult_seq

Sequential shift-add multiplier that sits directly downstream of the operand-load register stage. It consumes the registered operands and the `loaded` flag, computes the 2N-bit product over N iteration cycles, and returns a one-cycle `done` pulse that the load stage uses to clear `loaded`. Results are held stable on `product` until the next completed operation.

## Interface
- `N`, 4: operand width in bits; N ≥ 2.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  operands valid (load stage `loaded`); level-sensitive.
- `multiplicand`  in  N  operand A (load stage `reg_in`).
- `multiplier`  in  N  operand B (load stage `reg_in`).
- `product`  out  2N  result register.
- `done`  out  1  one-cycle completion pulse; drive to load stage `done`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding comes from the shared package.
- IDLE:
  - When `start`=1, capture operands into internal registers.
  - Clear the accumulator and iteration counter, then go to RUN.
  - When `start`=0, stay in IDLE.
- RUN, one iteration per cycle:
  - If the multiplier-shift LSB is 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
  - After iteration N (counter = N-1), load the accumulator result into `product` and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go unconditionally to IDLE.
- `start` is ignored in RUN and DONE. Operand changes after capture do not affect the result.
- Arithmetic:
  - Accumulator and shifted multiplicand are 2N bits wide.
  - The unsigned product always fits in 2N bits, so there is no overflow.
- `product` changes only on the RUN→DONE transition. It holds its value through IDLE and through the next RUN.
- Back-to-back operation:
  - The load stage clears `loaded` on the edge ending the `done` cycle.
  - If the load stage reloads in that same cycle, `start` stays 1 and a new operation begins from IDLE the next cycle. No operand is lost or reused.

## Timing
- Reset values: state=IDLE, `product`=0, `done`=0, `busy`=0; internal registers also 0.
- Reset mid-RUN or mid-DONE aborts the operation immediately: outputs return to reset values and no `done` is issued.
- Let edge E be the edge on which `start` is sampled in IDLE.
  - `busy` rises after E.
  - RUN occupies cycles E+1 … E+N.
  - `product` is valid and `done`=1 in the cycle after edge E+N.
  - `busy` falls after edge E+N+1.
- Start-to-done latency is N+1 cycles. Minimum issue interval is N+2 cycles.

## Configuration
- Macro: `MULT_SEQ_SIGNED_EN`.
- Defined:
  - Operands are two's complement. Capture their magnitudes and record the XOR of the sign bits.
  - Run the unsigned N-iteration loop on the magnitudes.
  - On RUN→DONE, write the 2N-bit two's-complement negation of the result when the sign XOR is 1.
  - The most negative operand magnitude (2^(N-1)) must be handled correctly; the N-bit magnitude holds it unsigned.
- Undefined: operands are unsigned. No sign logic is synthesised.
- Latency is identical in both builds.

## Structure
- `Pkg_Global` holds:
  - the FSM state enum typedef (IDLE, RUN, DONE);
  - the default width constant used for `N`;
  - a counter-width function returning $clog2(N).
- One sub-module: `bit_counter`, a parameterised up-counter with synchronous clear and enable and an asynchronous active-low reset. It provides the iteration count and a terminal-count flag that drives RUN→DONE.

## Test plan
- Unsigned, N=4: `start`=1, A=3, B=5 → `done` 5 cycles after the sampling edge, `product`=8'h0F, `busy` high for 5 cycles.
- Unsigned, N=4: A=15, B=15 → `product`=8'hE1. Then A=0, B=9 → `product`=8'h00, and the previous value holds until that DONE.
- Keep `start` high and change operands during RUN: 6×7 → `product`=8'h2A, unaffected by the mid-RUN changes. `start` held across `done` → a second operation starts immediately; `done` is seen every 6 cycles.
- Drop `rst` low two cycles into RUN → `product`=0, `done`=0, `busy`=0 at once. After release, a fresh 2×2 → 8'h04.
- With `MULT_SEQ_SIGNED_EN`, N=4:
  - −3×5 → 8'hF1
  - −8×−8 → 8'h40
  - 7×−1 → 8'hF9
- Without `MULT_SEQ_SIGNED_EN`, 4'hD×4'h5 → 8'h41.
